pc_stack_seq: RTL and testbench

PC_STACK_SEQ -- requirements
Module: pc_stack_seq

---
 rtl/pc_stack_seq.sv | 153 +++++++++++++++
 tb/tb_pc_stack_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_seq.sv
// pc_stack_seq: program counter built from a page field and a
// polynomial-counter low field, with a small hardware return stack.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   adv               sequential step of the low field
//   jmp, call, ret    jump / call (push) / return (pop); ret > call > jmp > adv
//   skip              with ret: step the popped PC once more
//   target            low-field destination for jmp/call
//   ssp_valid/page    page prefix for the next jmp/call (bypassed same cycle)
//   clr_err           clear sticky overflow/underflow (a new event wins)
//   pc                {page, low}
//   level/full/empty  stack occupancy
//   top               top stack entry, 0 when empty
//   overflow/underflow sticky error flags
//   pend              a stored page prefix is waiting to be used
module pc_stack_seq #(
    parameter int PL_W = 6,
    parameter int PU_W = 4,
    parameter int DEPTH = 4,
    parameter logic [PU_W-1:0] CALL_PAGE = {PU_W{1'b1}},
    localparam int PC_W = PU_W + PL_W,
    localparam int LV_W = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            adv,
    input  logic            jmp,
    input  logic            call,
    input  logic            ret,
    input  logic            skip,
    input  logic [PL_W-1:0] target,
    input  logic            ssp_valid,
    input  logic [PU_W-1:0] ssp_page,
    input  logic            clr_err,
    output logic [PC_W-1:0] pc,
    output logic [LV_W-1:0] level,
    output logic            full,
    output logic            empty,
    output logic [PC_W-1:0] top,
    output logic            overflow,
    output logic            underflow,
    output logic            pend
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [LV_W-1:0] level_q, level_d;
    logic [PC_W-1:0] stk_q [DEPTH];
    logic [PC_W-1:0] stk_d [DEPTH];
    logic [PU_W-1:0] pfx_q, pfx_d;
    logic            pend_q, pend_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic            eff_vld;
    logic [PU_W-1:0] eff_pg;
    logic [PC_W-1:0] top_w;
    logic            ovf_ev, unf_ev;

    // Polynomial-counter step: shift right, feed XNOR of the two LSBs into
    // the MSB. All-ones maps onto itself.
    function automatic logic [PL_W-1:0] step(input logic [PL_W-1:0] l);
        return {~(l[0] ^ l[1]), l[PL_W-1:1]};
    endfunction

    // Entry at index level-1 is the top; the loop avoids an index-width
    // mismatch between level and the array bound.
    always_comb begin
        top_w = '0;
        for (int i = 0; i < DEPTH; i++)
            if (level_q == LV_W'(i + 1)) top_w = stk_q[i];
    end

    // A same-cycle prefix bypasses the stored one.
    assign eff_vld = ssp_valid | pend_q;
    assign eff_pg  = ssp_valid ? ssp_page : pfx_q;

    always_comb begin
        pc_d    = pc_q;
        level_d = level_q;
        stk_d   = stk_q;
        pfx_d   = pfx_q;
        pend_d  = pend_q;
        ovf_ev  = 1'b0;
        unf_ev  = 1'b0;

        if (ret) begin
            pend_d = 1'b0;
            if (level_q != '0) begin
                pc_d    = skip ? {top_w[PC_W-1:PL_W], step(top_w[PL_W-1:0])} : top_w;
                level_d = level_q - 1'b1;
            end else begin
                unf_ev = 1'b1;
            end
        end else if (call) begin
            if (level_q == LV_W'(DEPTH)) begin
                // Full: drop the oldest entry, shift down, push on top.
                for (int i = 0; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
                stk_d[DEPTH-1] = pc_q;
                ovf_ev = 1'b1;
            end else begin
                for (int i = 0; i < DEPTH; i++)
                    if (level_q == LV_W'(i)) stk_d[i] = pc_q;
                level_d = level_q + 1'b1;
            end
            pc_d   = {eff_vld ? eff_pg : CALL_PAGE, target};
            pend_d = 1'b0;
        end else if (jmp) begin
            pc_d   = {eff_vld ? eff_pg : pc_q[PC_W-1:PL_W], target};
            pend_d = 1'b0;
        end else begin
            if (adv) pc_d = {pc_q[PC_W-1:PL_W], step(pc_q[PL_W-1:0])};
            if (ssp_valid) begin
                pfx_d  = ssp_page;
                pend_d = 1'b1;
            end
        end

        // Sticky flags: a new event overrides a simultaneous clear.
        ovf_d = (ovf_q & ~clr_err) | ovf_ev;
        unf_d = (unf_q & ~clr_err) | unf_ev;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
            pfx_q   <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            level_q <= level_d;
            stk_q   <= stk_d;
            pfx_q   <= pfx_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign pc        = pc_q;
    assign level     = level_q;
    assign full      = (level_q == LV_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign top       = top_w;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign pend      = pend_q;

endmodule

// File: tb/tb_pc_stack_seq.sv
// Testbench for pc_stack_seq: directed scenarios followed by random ops.
// The driver updates a queue-based reference model and pushes the expected
// post-edge output state; a monitor pops and compares after every edge.
module tb_pc_stack_seq;

    localparam int PL_W = 6;
    localparam int PU_W = 4;
    localparam int DEPTH = 4;
    localparam int PC_W = PU_W + PL_W;
    localparam int LV_W = $clog2(DEPTH + 1);
    localparam int CALL_PG = (1 << PU_W) - 1;
    localparam int LMASK = (1 << PL_W) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            adv = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0, skip = 1'b0;
    logic [PL_W-1:0] target = '0;
    logic            ssp_valid = 1'b0;
    logic [PU_W-1:0] ssp_page = '0;
    logic            clr_err = 1'b0;
    logic [PC_W-1:0] pc, top;
    logic [LV_W-1:0] level;
    logic            full, empty, overflow, underflow, pend;

    pc_stack_seq #(.PL_W(PL_W), .PU_W(PU_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .adv(adv), .jmp(jmp), .call(call), .ret(ret),
        .skip(skip), .target(target), .ssp_valid(ssp_valid), .ssp_page(ssp_page),
        .clr_err(clr_err), .pc(pc), .level(level), .full(full), .empty(empty),
        .top(top), .overflow(overflow), .underflow(underflow), .pend(pend)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [LV_W-1:0] level;
        logic            full;
        logic            empty;
        logic [PC_W-1:0] top;
        logic            ovf;
        logic            unf;
        logic            pend;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    // Reference model state
    int m_page = 0, m_low = 0, m_pfx = 0;
    bit m_pend = 0, m_ovf = 0, m_unf = 0;
    int m_stk[$];

    function automatic int step(int l);
        int b;
        b = (~(l ^ (l >> 1))) & 1;
        return ((l >> 1) | (b << (PL_W - 1))) & LMASK;
    endfunction

    task automatic model(bit a, bit j, bit c, bit r, bit s, int t, bit v, int p,
                         bit ce, bit rs);
        bit have, oe, ue;
        int pg, x;
        obs_t e;
        if (rs) begin
            m_page = 0; m_low = 0; m_pfx = 0; m_pend = 0; m_ovf = 0; m_unf = 0;
            m_stk.delete();
        end else begin
            oe = 0; ue = 0; have = 0; pg = 0;
            if (v) begin have = 1; pg = p; end
            else if (m_pend) begin have = 1; pg = m_pfx; end
            if (r) begin
                m_pend = 0;
                if (m_stk.size() > 0) begin
                    x = m_stk.pop_back();
                    m_page = x >> PL_W;
                    m_low = x & LMASK;
                    if (s) m_low = step(m_low);
                end else ue = 1;
            end else if (c) begin
                m_stk.push_back(m_page * (1 << PL_W) + m_low);
                if (m_stk.size() > DEPTH) begin
                    x = m_stk.pop_front();
                    oe = 1;
                end
                m_page = have ? pg : CALL_PG;
                m_low = t;
                m_pend = 0;
            end else if (j) begin
                if (have) m_page = pg;
                m_low = t;
                m_pend = 0;
            end else begin
                if (a) m_low = step(m_low);
                if (v) begin m_pfx = p; m_pend = 1; end
            end
            m_ovf = (m_ovf && !ce) || oe;
            m_unf = (m_unf && !ce) || ue;
        end
        e.pc    = PC_W'(m_page * (1 << PL_W) + m_low);
        e.level = LV_W'(m_stk.size());
        e.full  = (m_stk.size() == DEPTH);
        e.empty = (m_stk.size() == 0);
        e.top   = (m_stk.size() > 0) ? PC_W'(m_stk[$]) : '0;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.pend  = m_pend;
        exp_q.push_back(e);
    endtask

    task automatic drive(bit a, bit j, bit c, bit r, bit s, int t, bit v, int p,
                         bit ce, bit rs);
        @(negedge clk);
        adv = a; jmp = j; call = c; ret = r; skip = s;
        target = PL_W'(t); ssp_valid = v; ssp_page = PU_W'(p);
        clr_err = ce; rst = rs;
        model(a, j, c, r, s, t & LMASK, v, p & CALL_PG, ce, rs);
    endtask

    task automatic do_rst();   drive(0,0,0,0,0,0,0,0,0,1); endtask
    task automatic do_adv();   drive(1,0,0,0,0,0,0,0,0,0); endtask
    task automatic do_jmp(int t);  drive(0,1,0,0,0,t,0,0,0,0); endtask
    task automatic do_call(int t); drive(0,0,1,0,0,t,0,0,0,0); endtask
    task automatic do_ret(bit s);  drive(0,0,0,1,s,0,0,0,0,0); endtask

    // Monitor: every cycle is an output event for this block.
    initial begin
        obs_t e, g;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g.pc = pc; g.level = level; g.full = full; g.empty = empty;
                g.top = top; g.ovf = overflow; g.unf = underflow; g.pend = pend;
                n_cmp++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL state cyc=%0d got pc=%h lvl=%0d f=%b e=%b top=%h ov=%b un=%b pd=%b want pc=%h lvl=%0d f=%b e=%b top=%h ov=%b un=%b pd=%b",
                             cyc, g.pc, g.level, g.full, g.empty, g.top, g.ovf, g.unf, g.pend,
                             e.pc, e.level, e.full, e.empty, e.top, e.ovf, e.unf, e.pend);
                end
            end
        end
    end

    initial begin
        bit a, j, c, r, s, v, ce, rs;
        // Reset, three sequential steps: 0x20, 0x30, 0x38
        do_rst();
        do_rst();
        do_adv(); do_adv(); do_adv();
        // Call from 0x038 into the default call page, return with skip
        do_call(5);
        do_ret(1);
        // Stored prefix consumed by jmp; bypass prefix on call
        drive(0,0,0,0,0,0,1,3,0,0);
        do_adv();
        do_jmp('h11);
        drive(0,0,1,0,0,'h2A,1,6,0,0);
        do_ret(0);
        // Five calls from distinct PCs -> overflow, then drain + underflow
        for (int i = 1; i <= 5; i++) do_call(i * 3);
        for (int i = 0; i < 5; i++) do_ret(0);
        drive(0,0,0,0,0,0,0,0,1,0);
        // jmp+call+ret together at level 1: ret only
        do_call(7);
        drive(0,1,1,1,0,9,0,0,0,0);
        // Mid-sequence reset with level 3, pend, errors set
        do_ret(0);
        do_call(1); do_call(2); do_call(3);
        drive(0,0,0,0,0,0,1,5,0,0);
        do_rst();
        // clr_err together with an overflow: flag stays set
        for (int i = 0; i < 4; i++) do_call(i + 8);
        drive(0,0,1,0,0,'h3F,0,0,1,0);
        drive(0,0,0,0,0,0,0,0,1,0);
        // All-ones low field is a fixed point
        do_jmp('h3F);
        do_adv();
        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            a  = ($urandom_range(99) < 50);
            j  = ($urandom_range(99) < 12);
            c  = ($urandom_range(99) < 20);
            r  = ($urandom_range(99) < 18);
            s  = $urandom_range(1);
            v  = ($urandom_range(99) < 20);
            ce = ($urandom_range(99) < 6);
            rs = ($urandom_range(999) < 8);
            drive(a, j, c, r, s, $urandom_range(LMASK), v, $urandom_range(CALL_PG), ce, rs);
        end
        drive(0,0,0,0,0,0,0,0,0,0);
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain left=%0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
